// File: rtl/distancias_pkg.sv
// rtl/distancias_pkg.sv - cell codes, search FSM states and quadrant indices for distancias
package distancias_pkg;

   typedef enum logic [1:0] {
      LIVRE     = 2'd0,
      VISITADO  = 2'd1,
      OBSTACULO = 2'd2,
      ALVO      = 2'd3
   } cell_t;

   typedef enum logic [1:0] {
      IDLE,
      SEARCH,
      DONE
   } estado_t;

   localparam int Q_DF          = 0;
   localparam int Q_EF          = 1;
   localparam int Q_ET          = 2;
   localparam int Q_DT          = 3;
   localparam int NumQuadrantes = 4;

endpackage

// File: rtl/distancias_quadrante.sv
// rtl/distancias_quadrante.sv - candidate cell of one quadrant for ring radius r, step k
module distancias_quadrante
   import distancias_pkg::*;
#(
   parameter int Q                = Q_DF,
   parameter int TamanhoMalha     = 8,
   parameter int tamanhoDistancia = 8
) (
   input  logic [tamanhoDistancia-1:0] x,
   input  logic [tamanhoDistancia-1:0] y,
   input  logic [tamanhoDistancia-1:0] r,
   input  logic [tamanhoDistancia-1:0] k,
   output logic [tamanhoDistancia-1:0] cx,
   output logic [tamanhoDistancia-1:0] cy,
   output logic                        dentro
);

   localparam int SW = tamanhoDistancia + 2;
   localparam logic signed [SW-1:0] Limite = SW'(TamanhoMalha - 1);

   logic signed [SW-1:0] sx, sy, sr, sk, px, py;

   always_comb begin
      sx = $signed({2'b00, x});
      sy = $signed({2'b00, y});
      sr = $signed({2'b00, r});
      sk = $signed({2'b00, k});
      case (Q)
         Q_EF:    begin px = sx - sk;      py = sy + sr - sk; end
         Q_ET:    begin px = sx - sr + sk; py = sy - sk;      end
         Q_DT:    begin px = sx + sk;      py = sy - sr + sk; end
         default: begin px = sx + sr - sk; py = sy + sk;      end
      endcase
      // Sign bit set means the candidate fell off the low edge of the grid.
      dentro = !px[SW-1] && !py[SW-1] && (px <= Limite) && (py <= Limite);
      cx     = px[tamanhoDistancia-1:0];
      cy     = py[tamanhoDistancia-1:0];
   end

endmodule

// File: rtl/distancias.sv
// rtl/distancias.sv - nearest-target ring search over the occupancy grid; DISTANCIAS_SNAPSHOT_EN copies malha at start
module distancias
   import distancias_pkg::*;
#(
   parameter int TamanhoMalha     = 8,
   parameter int tamanhoDistancia = 8
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic [tamanhoDistancia-1:0] posicaoAtualnoEixoX,
   input  logic [tamanhoDistancia-1:0] posicaoAtualnoEixoY,
   input  logic                        novoDado,
   input  logic [1:0]                  malha [TamanhoMalha*TamanhoMalha],
   input  logic [3:0]                  enable,
   output logic                        operacaoFinalizada,
   output logic [tamanhoDistancia-1:0] destinoX,
   output logic [tamanhoDistancia-1:0] destinoY
);

   localparam int W          = tamanhoDistancia;
   localparam int NumCelulas = TamanhoMalha * TamanhoMalha;
   localparam int IdxW       = $clog2(NumCelulas);
   localparam logic [W-1:0] RaioMax = W'(2 * TamanhoMalha - 2);

   estado_t        estado, estadoProx;
   logic [W-1:0]   raio, raioProx, passo, passoProx;
   logic [W-1:0]   posX, posXProx, posY, posYProx;
   logic [W-1:0]   destXProx, destYProx;
   logic           finProx;

   logic [1:0]     grade [NumCelulas];

`ifdef DISTANCIAS_SNAPSHOT_EN
   logic inicio;
   assign inicio = novoDado && (estado != SEARCH);

   always_ff @(posedge clock) begin
      if (inicio) grade <= malha;
   end
`else
   assign grade = malha;
`endif

   logic [W-1:0]               candX [NumQuadrantes];
   logic [W-1:0]               candY [NumQuadrantes];
   logic [NumQuadrantes-1:0]   dentro, acerto;

   for (genvar q = 0; q < NumQuadrantes; q++) begin : gQuad
      logic [IdxW-1:0] indice;

      distancias_quadrante #(
         .Q                (q),
         .TamanhoMalha     (TamanhoMalha),
         .tamanhoDistancia (tamanhoDistancia)
      ) uQuad (
         .x      (posX),
         .y      (posY),
         .r      (raio),
         .k      (passo),
         .cx     (candX[q]),
         .cy     (candY[q]),
         .dentro (dentro[q])
      );

      // Out-of-range candidates are steered to cell 0 so the array read stays legal.
      assign indice = dentro[q] ? IdxW'(candX[q]) + IdxW'(candY[q]) * IdxW'(TamanhoMalha) : '0;
      assign acerto[q] = enable[q] && dentro[q] && (cell_t'(grade[indice]) == ALVO);
   end

   logic [W-1:0] escolhaX, escolhaY;

   always_comb begin
      escolhaX = '0;
      escolhaY = '0;
      for (int q = NumQuadrantes - 1; q >= 0; q--) begin
         if (acerto[q]) begin
            escolhaX = candX[q];
            escolhaY = candY[q];
         end
      end
   end

   always_comb begin
      estadoProx = estado;
      raioProx   = raio;
      passoProx  = passo;
      posXProx   = posX;
      posYProx   = posY;
      destXProx  = destinoX;
      destYProx  = destinoY;
      finProx    = operacaoFinalizada;
      case (estado)
         IDLE, DONE: begin
            if (novoDado) begin
               estadoProx = SEARCH;
               posXProx   = posicaoAtualnoEixoX;
               posYProx   = posicaoAtualnoEixoY;
               raioProx   = W'(1);
               passoProx  = '0;
               finProx    = 1'b0;
            end
         end
         SEARCH: begin
            if (|acerto) begin
               destXProx  = escolhaX;
               destYProx  = escolhaY;
               finProx    = 1'b1;
               estadoProx = DONE;
            end else if (passo == raio - W'(1)) begin
               if (raio == RaioMax) begin
                  destXProx  = posX;
                  destYProx  = posY;
                  finProx    = 1'b1;
                  estadoProx = DONE;
               end else begin
                  raioProx  = raio + W'(1);
                  passoProx = '0;
               end
            end else begin
               passoProx = passo + W'(1);
            end
         end
         default: estadoProx = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         estado             <= IDLE;
         raio               <= W'(1);
         passo              <= '0;
         posX               <= '0;
         posY               <= '0;
         destinoX           <= '0;
         destinoY           <= '0;
         operacaoFinalizada <= 1'b0;
      end else begin
         estado             <= estadoProx;
         raio               <= raioProx;
         passo              <= passoProx;
         posX               <= posXProx;
         posY               <= posYProx;
         destinoX           <= destXProx;
         destinoY           <= destYProx;
         operacaoFinalizada <= finProx;
      end
   end

endmodule

// File: tb/tb_distancias.sv
// tb/tb_distancias.sv - scoreboard bench for distancias with directed search vectors
module tb_distancias;

   localparam int N = 8;
   localparam int W = 8;

   logic          clock = 1'b0;
   logic          reset;
   logic          novoDado;
   logic [W-1:0]  posX, posY;
   logic [1:0]    malha [N*N];
   logic [3:0]    enable;
   logic          operacaoFinalizada;
   logic [W-1:0]  destinoX, destinoY;

   distancias #(
      .TamanhoMalha     (N),
      .tamanhoDistancia (W)
   ) dut (
      .clock               (clock),
      .reset               (reset),
      .posicaoAtualnoEixoX (posX),
      .posicaoAtualnoEixoY (posY),
      .novoDado            (novoDado),
      .malha               (malha),
      .enable              (enable),
      .operacaoFinalizada  (operacaoFinalizada),
      .destinoX            (destinoX),
      .destinoY            (destinoY)
   );

   always #5 clock = ~clock;

   int edgeCount = 0;
   always @(posedge clock) edgeCount <= edgeCount + 1;

   typedef struct {
      int    x;
      int    y;
      int    lat;
      string name;
   } esperado_t;

   esperado_t fila [$];
   int        checks = 0;
   int        errors = 0;
   int        startEdge = 0;
   bit        finPrev = 1'b0;

   task automatic check(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", name, actual, expected);
      end
   endtask

   task automatic limpar();
      for (int i = 0; i < N*N; i++) malha[i] = 2'b00;
   endtask

   task automatic alvo(input int x, input int y);
      malha[x + y*N] = 2'b11;
   endtask

   task automatic iniciar(input int px, input int py, input logic [3:0] en, input bit push,
                          input int ex, input int ey, input int lat, input string name);
      esperado_t e;
      @(negedge clock);
      posX   = W'(px);
      posY   = W'(py);
      enable = en;
      if (push) begin
         e.x = ex; e.y = ey; e.lat = lat; e.name = name;
         fila.push_back(e);
      end
      novoDado = 1'b1;
      @(posedge clock);
      #1;
      startEdge = edgeCount;
      check({name, "_fin_drop"}, int'(operacaoFinalizada), 0);
      @(negedge clock);
      novoDado = 1'b0;
   endtask

   task automatic esperar(input string name);
      int n;
      n = 0;
      while (operacaoFinalizada !== 1'b1 && n < 300) begin
         @(negedge clock);
         n++;
      end
      check({name, "_done"}, int'(operacaoFinalizada), 1);
      @(negedge clock);
   endtask

   initial begin
      reset    = 1'b1;
      novoDado = 1'b0;
      posX     = '0;
      posY     = '0;
      enable   = 4'b0000;
      limpar();

      fork
         forever begin
            esperado_t e;
            @(negedge clock);
            if (operacaoFinalizada === 1'b1 && !finPrev) begin
               if (fila.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_done actual=1 expected=0");
               end else begin
                  e = fila.pop_front();
                  check({e.name, "_x"}, int'(destinoX), e.x);
                  check({e.name, "_y"}, int'(destinoY), e.y);
                  check({e.name, "_lat"}, edgeCount - startEdge, e.lat);
               end
            end
            finPrev = (operacaoFinalizada === 1'b1);
         end
      join_none

      repeat (2) @(posedge clock);
      #1;
      check("reset_fin", int'(operacaoFinalizada), 0);
      check("reset_x", int'(destinoX), 0);
      check("reset_y", int'(destinoY), 0);
      @(negedge clock);
      reset = 1'b0;

      // Single target at radius 5, step 3.
      alvo(2, 3);
      iniciar(0, 0, 4'b1111, 1, 2, 3, 14, "t1");
      esperar("t1");
      repeat (5) @(negedge clock);
      check("t1_hold_fin", int'(operacaoFinalizada), 1);
      check("t1_hold_x", int'(destinoX), 2);

      limpar();
      iniciar(3, 3, 4'b1111, 1, 3, 3, 105, "t2_empty");
      esperar("t2_empty");

      // q0 and q1 both hit at r=1,k=0; q0 wins.
      alvo(4, 3);
      alvo(3, 4);
      iniciar(3, 3, 4'b1111, 1, 4, 3, 1, "t3_prio");
      esperar("t3_prio");

      limpar();
      alvo(1, 1);
      iniciar(3, 3, 4'b0001, 1, 3, 3, 105, "t4_masked");
      esperar("t4_masked");
      iniciar(3, 3, 4'b0100, 1, 1, 1, 9, "t4_q2");
      esperar("t4_q2");

      limpar();
      iniciar(3, 3, 4'b1111, 0, 0, 0, 0, "t5_abort");
      repeat (10) @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      #1;
      check("t5_reset_fin", int'(operacaoFinalizada), 0);
      check("t5_reset_x", int'(destinoX), 0);
      check("t5_reset_y", int'(destinoY), 0);
      @(negedge clock);
      reset = 1'b0;
      alvo(5, 6);
      iniciar(3, 3, 4'b1111, 1, 5, 6, 14, "t5_fresh");
      esperar("t5_fresh");

      limpar();
      alvo(3, 1);
      iniciar(3, 3, 4'b1111, 1, 3, 1, 2, "t6_move");
      esperar("t6_move");

      // Far corner: target found on the very last ring.
      limpar();
      alvo(0, 0);
      iniciar(7, 7, 4'b1111, 1, 0, 0, 99, "t7_corner");
      esperar("t7_corner");

      repeat (2) @(negedge clock);
      check("queue_empty", fila.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
